// File: rtl/imul_pkg.sv
// Shared multiplier types: operand/pair widths and the {a, b} pair
// layout that the multiplier's 64-bit receive port consumes directly.
package imul_pkg;

   localparam int IMUL_OPERAND_NBITS = 32;
   localparam int IMUL_PAIR_NBITS    = 64;

   // a lands in [63:32], b in [31:0]
   typedef struct packed {
      logic [IMUL_OPERAND_NBITS-1:0] a;
      logic [IMUL_OPERAND_NBITS-1:0] b;
   } imul_pair_t;

endpackage

// File: rtl/imul_operand_queue.sv
// Normal (non-bypass) FIFO with val/rdy on both sides.
// Ports: clk, reset, enq_{val,rdy,msg}, deq_{val,rdy,msg}.
module imul_operand_queue
   import imul_pkg::*;
#(
   parameter int p_num_entries = 2,
   parameter int p_nbits       = IMUL_OPERAND_NBITS
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               enq_val,
   output logic               enq_rdy,
   input  logic [p_nbits-1:0] enq_msg,
   output logic               deq_val,
   input  logic               deq_rdy,
   output logic [p_nbits-1:0] deq_msg
);

   localparam int PW = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(p_num_entries);

   logic [p_nbits-1:0] storage [p_num_entries];
   logic [PW-1:0]      enq_ptr;
   logic [PW-1:0]      deq_ptr;
   logic [CW-1:0]      count;
   logic               enq_go;
   logic               deq_go;

   // Ready comes from registered count only: no full-queue bypass.
   assign enq_rdy = (count != FULL);
   assign deq_val = (count != '0);
   assign deq_msg = storage[deq_ptr];

   assign enq_go  = enq_val & enq_rdy;
   assign deq_go  = deq_val & deq_rdy;

   // Depth is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         enq_ptr <= '0;
         deq_ptr <= '0;
         count   <= '0;
      end else begin
         if (enq_go)
            enq_ptr <= enq_ptr + PW'(1);
         if (deq_go)
            deq_ptr <= deq_ptr + PW'(1);
         unique case ({enq_go, deq_go})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (enq_go)
         storage[enq_ptr] <= enq_msg;
   end

endmodule

// File: rtl/imul_operand_join.sv
// Operand join: pairs A and B operands in arrival order into {a, b}.
// Ports: clk, reset, recv_a_*, recv_b_*, send_* (val/rdy streams).
module imul_operand_join
   import imul_pkg::*;
#(
   parameter int p_num_entries = 2
)(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          recv_a_val,
   output logic                          recv_a_rdy,
   input  logic [IMUL_OPERAND_NBITS-1:0] recv_a_msg,
   input  logic                          recv_b_val,
   output logic                          recv_b_rdy,
   input  logic [IMUL_OPERAND_NBITS-1:0] recv_b_msg,
   output logic                          send_val,
   input  logic                          send_rdy,
   output logic [IMUL_PAIR_NBITS-1:0]    send_msg
);

   logic                          a_val;
   logic                          b_val;
   logic [IMUL_OPERAND_NBITS-1:0] a_msg;
   logic [IMUL_OPERAND_NBITS-1:0] b_msg;
   logic                          send_go;
   imul_pair_t                    pair;

   imul_operand_queue #(
      .p_num_entries (p_num_entries),
      .p_nbits       (IMUL_OPERAND_NBITS)
   ) a_q (
      .clk     (clk),
      .reset   (reset),
      .enq_val (recv_a_val),
      .enq_rdy (recv_a_rdy),
      .enq_msg (recv_a_msg),
      .deq_val (a_val),
      .deq_rdy (send_go),
      .deq_msg (a_msg)
   );

   imul_operand_queue #(
      .p_num_entries (p_num_entries),
      .p_nbits       (IMUL_OPERAND_NBITS)
   ) b_q (
      .clk     (clk),
      .reset   (reset),
      .enq_val (recv_b_val),
      .enq_rdy (recv_b_rdy),
      .enq_msg (recv_b_msg),
      .deq_val (b_val),
      .deq_rdy (send_go),
      .deq_msg (b_msg)
   );

   // Both queues pop together, so pairing order can never slip.
   assign send_val = a_val & b_val;
   assign send_go  = send_val & send_rdy;

   assign pair.a   = a_msg;
   assign pair.b   = b_msg;

   // Zero-mask hides stale storage when no pair is offered.
   assign send_msg = send_val ? pair : '0;

endmodule

// File: tb/tb_imul_operand_join.sv
// Directed self-checking bench for imul_operand_join.
// Drives inputs #1 after posedge and samples outputs there too.
module tb_imul_operand_join;

   logic        clk = 1'b0;
   logic        reset;
   logic        recv_a_val;
   logic        recv_a_rdy;
   logic [31:0] recv_a_msg;
   logic        recv_b_val;
   logic        recv_b_rdy;
   logic [31:0] recv_b_msg;
   logic        send_val;
   logic        send_rdy;
   logic [63:0] send_msg;

   int vectors = 0;
   int errors  = 0;

   imul_operand_join #(.p_num_entries(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .recv_a_val (recv_a_val),
      .recv_a_rdy (recv_a_rdy),
      .recv_a_msg (recv_a_msg),
      .recv_b_val (recv_b_val),
      .recv_b_rdy (recv_b_rdy),
      .recv_b_msg (recv_b_msg),
      .send_val   (send_val),
      .send_rdy   (send_rdy),
      .send_msg   (send_msg)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_val"}, 64'(send_val), 64'd0);
      chk({tag, "_msg"}, send_msg, 64'd0);
   endtask

   task automatic chk_pair(input string tag,
                           input logic [31:0] a,
                           input logic [31:0] b);
      chk({tag, "_val"}, 64'(send_val), 64'd1);
      chk({tag, "_msg"}, send_msg, {a, b});
   endtask

   task automatic drive(input logic av, input logic [31:0] am,
                        input logic bv, input logic [31:0] bm);
      recv_a_val = av;
      recv_a_msg = am;
      recv_b_val = bv;
      recv_b_msg = bm;
   endtask

   int ai;
   int bi;
   int oi;
   logic go_a;
   logic go_b;

   initial begin
      reset    = 1'b1;
      send_rdy = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 32'h0);
      tick();
      tick();
      reset = 1'b0;

      // reset state
      chk("rst_a_rdy", 64'(recv_a_rdy), 64'd1);
      chk("rst_b_rdy", 64'(recv_b_rdy), 64'd1);
      chk_idle("rst");

      // basic pair
      send_rdy = 1'b1;
      drive(1'b1, 32'h3, 1'b1, 32'h5);
      tick();
      drive(1'b0, 32'h0, 1'b0, 32'h0);
      chk_pair("basic", 32'h3, 32'h5);
      tick();
      chk_idle("basic_done");

      // skewed arrival
      drive(1'b1, 32'hDEADBEEF, 1'b0, 32'h0);
      tick();
      drive(1'b0, 32'h0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         chk("skew_wait_val", 64'(send_val), 64'd0);
         chk("skew_a_rdy", 64'(recv_a_rdy), 64'd1);
         tick();
      end
      drive(1'b0, 32'h0, 1'b1, 32'h1);
      chk("skew_pre_val", 64'(send_val), 64'd0);
      tick();
      drive(1'b0, 32'h0, 1'b0, 32'h0);
      chk_pair("skew", 32'hDEADBEEF, 32'h1);
      tick();
      chk_idle("skew_done");

      // backpressure / full
      send_rdy = 1'b0;
      drive(1'b1, 32'h1, 1'b1, 32'h2);
      tick();
      chk("bp1_a_rdy", 64'(recv_a_rdy), 64'd1);
      drive(1'b1, 32'h3, 1'b1, 32'h4);
      tick();
      chk("bp2_a_rdy", 64'(recv_a_rdy), 64'd0);
      chk("bp2_b_rdy", 64'(recv_b_rdy), 64'd0);
      chk_pair("bp2_head", 32'h1, 32'h2);
      drive(1'b1, 32'h5, 1'b1, 32'h6);
      tick();
      chk("bp3_a_rdy", 64'(recv_a_rdy), 64'd0);
      chk("bp3_b_rdy", 64'(recv_b_rdy), 64'd0);
      chk_pair("bp3_stable", 32'h1, 32'h2);
      send_rdy = 1'b1;
      tick();
      chk_pair("bp_out2", 32'h3, 32'h4);
      chk("bp_rdy_back_a", 64'(recv_a_rdy), 64'd1);
      chk("bp_rdy_back_b", 64'(recv_b_rdy), 64'd1);
      tick();
      drive(1'b0, 32'h0, 1'b0, 32'h0);
      chk_pair("bp_out3", 32'h5, 32'h6);
      tick();
      chk_idle("bp_done");

      // streaming with pointer wrap
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 32'(i), 1'b1, 32'(2 * i));
         tick();
         chk_pair("stream", 32'(i), 32'(2 * i));
      end
      drive(1'b0, 32'h0, 1'b0, 32'h0);
      tick();
      chk_idle("stream_done");

      // imbalance: A runs ahead, then B catches up
      ai = 0;
      bi = 0;
      oi = 0;
      for (int c = 0; c < 4; c++) begin
         drive(ai < 5, 32'h10 + 32'(ai), 1'b0, 32'h0);
         go_a = recv_a_val & recv_a_rdy;
         tick();
         if (go_a) ai++;
      end
      chk("imb_a_count", 64'(ai), 64'd2);
      chk("imb_a_rdy", 64'(recv_a_rdy), 64'd0);
      chk("imb_no_val", 64'(send_val), 64'd0);
      for (int c = 0; c < 40 && oi < 5; c++) begin
         drive(ai < 5, 32'h10 + 32'(ai), bi < 5, 32'h20 + 32'(bi));
         go_a = recv_a_val & recv_a_rdy;
         go_b = recv_b_val & recv_b_rdy;
         if (send_val) begin
            chk("imb_pair", send_msg,
                {32'h10 + 32'(oi), 32'h20 + 32'(oi)});
            oi++;
         end
         tick();
         if (go_a) ai++;
         if (go_b) bi++;
      end
      drive(1'b0, 32'h0, 1'b0, 32'h0);
      chk("imb_pairs_out", 64'(oi), 64'd5);
      chk_idle("imb_done");

      // reset mid-operation
      send_rdy = 1'b0;
      drive(1'b1, 32'h41, 1'b0, 32'h0);
      tick();
      drive(1'b1, 32'h42, 1'b1, 32'h51);
      tick();
      drive(1'b0, 32'h0, 1'b0, 32'h0);
      chk_pair("pre_rst", 32'h41, 32'h51);
      reset = 1'b1;
      drive(1'b1, 32'hBAD, 1'b0, 32'h0);
      tick();
      reset = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 32'h0);
      chk_idle("mid_rst");
      chk("mid_rst_a_rdy", 64'(recv_a_rdy), 64'd1);
      chk("mid_rst_b_rdy", 64'(recv_b_rdy), 64'd1);
      send_rdy = 1'b1;
      drive(1'b1, 32'h7, 1'b1, 32'h9);
      tick();
      drive(1'b0, 32'h0, 1'b0, 32'h0);
      chk_pair("post_rst", 32'h7, 32'h9);
      tick();
      chk_idle("post_rst_done");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
